// File: rtl/bin2bcd_seq_if.sv
// Start/result handshake between board control logic and the binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Out-of-range results are flagged and every digit is forced to 4'hF so the display blanks.
module bin2bcd_seq #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic           clk,
  input logic           rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned DW   = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic            sticky_q, sticky_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [DW-1:0]   adj;

  // Add-3 correction per digit; no carry crosses a digit boundary.
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    dig_d    = dig_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sh_d     = bus.bin;
          dig_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        dig_d    = {adj[DW-2:0], sh_q[W-1]};
        sh_d     = sh_q << 1;
        sticky_d = sticky_q | adj[DW-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = sticky_q ? '1 : dig_q;
        ovf_d   = sticky_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sh_q     <= '0;
      dig_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      dig_q    <= dig_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench: a 3-digit and a 2-digit converter checked against a decimal reference model.
module tb_bin2bcd_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.W(W), .DIGITS(3)) if3 ();
  bin2bcd_seq_if #(.W(W), .DIGITS(2)) if2 ();

  bin2bcd_seq #(.W(W), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  bin2bcd_seq #(.W(W), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   done3  = 0;
  int   done2  = 0;
  int   k3;
  exp_t q3[$];
  exp_t q2[$];
  int   dcyc3[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits by division; anything above 10^d - 1 is blanked.
  function automatic exp_t model(int unsigned v, int unsigned d);
    exp_t        e;
    int unsigned lim = 1;
    int unsigned r   = v;
    e.bcd = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < int'(d); i++) lim = lim * 10;
    if (v >= lim) begin
      e.ovf = 1'b1;
      for (int i = 0; i < int'(d); i++) e.bcd[4*i +: 4] = 4'hF;
    end else begin
      for (int i = 0; i < int'(d); i++) begin
        e.bcd[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && if3.done) begin
      done3++;
      dcyc3.push_back(cyc);
      if (q3.size() == 0) check("dut3 unexpected done", 1, 0);
      else begin
        e = q3.pop_front();
        check("dut3 bcd", 32'(if3.bcd), 32'(e.bcd));
        check("dut3 overflow", 32'(if3.overflow), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && if2.done) begin
      done2++;
      if (q2.size() == 0) check("dut2 unexpected done", 1, 0);
      else begin
        e = q2.pop_front();
        check("dut2 bcd", 32'(if2.bcd), 32'(e.bcd[7:0]));
        check("dut2 overflow", 32'(if2.overflow), 32'(e.ovf));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic issue3(int unsigned v, bit push);
    if3.start = 1'b1;
    if3.bin   = 8'(v);
    @(negedge clk);
    if3.start = 1'b0;
    k3 = cyc;
    if (push) q3.push_back(model(v, 3));
  endtask

  task automatic issue2(int unsigned v);
    if2.start = 1'b1;
    if2.bin   = 8'(v);
    @(negedge clk);
    if2.start = 1'b0;
    q2.push_back(model(v, 2));
  endtask

  task automatic latency3(int unsigned v);
    issue3(v, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check($sformatf("busy v=%0d edge k+%0d", v, n), 32'(if3.busy), 32'(n < 9));
      check($sformatf("done v=%0d edge k+%0d", v, n), 32'(if3.done), 32'(n == 9));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if3.busy || if2.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d0;
    int r;
    int unsigned v;
    if3.start = 1'b0;
    if3.bin   = '0;
    if2.start = 1'b0;
    if2.bin   = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(if3.busy), 0);
    check("reset done", 32'(if3.done), 0);
    check("reset bcd", 32'(if3.bcd), 0);
    check("reset overflow", 32'(if3.overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    latency3(0);
    wait_idle();
    latency3(255);
    wait_idle();
    check("hold bcd 255", 32'(if3.bcd), 32'h255);

    // Second start while busy must be ignored.
    d0 = done3;
    issue3(99, 1'b1);
    repeat (2) @(negedge clk);
    if3.start = 1'b1;
    if3.bin   = 8'd200;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored start done count", 32'(done3 - d0), 1);
    check("ignored start bcd", 32'(if3.bcd), 32'h099);

    // Reset mid-conversion aborts without a done pulse.
    d0 = done3;
    issue3(123, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(if3.busy), 0);
    check("abort bcd", 32'(if3.bcd), 0);
    check("abort overflow", 32'(if3.overflow), 0);
    repeat (12) @(negedge clk);
    check("abort no done", 32'(done3 - d0), 0);

    issue2(100);
    wait_idle();
    check("dut2 hold ovf", 32'(if2.overflow), 1);
    check("dut2 hold bcd ff", 32'(if2.bcd), 32'hFF);
    issue2(42);
    wait_idle();
    check("dut2 hold bcd 42", 32'(if2.bcd), 32'h42);

    // Back-to-back with start held high.
    d0 = done3;
    if3.start = 1'b1;
    if3.bin   = 8'd37;
    @(negedge clk);
    k3 = cyc;
    if3.bin = 8'd58;
    q3.push_back(model(37, 3));
    q3.push_back(model(58, 3));
    repeat (10) @(negedge clk);
    if3.start = 1'b0;
    repeat (10) @(negedge clk);
    check("b2b done count", 32'(done3 - d0), 2);
    if (done3 - d0 >= 2) begin
      check("b2b first done edge", 32'(dcyc3[dcyc3.size()-2] - k3), 9);
      check("b2b second done edge", 32'(dcyc3[dcyc3.size()-1] - k3), 19);
    end

    // Randomized traffic, including starts that land while busy.
    for (int c = 0; c < 800; c++) begin
      r = int'($urandom % 8);
      v = (r == 0) ? 0 : (r == 1) ? 255 : (r == 2) ? 99 : (r == 3) ? 100 : $urandom % 256;
      if3.bin = 8'(v);
      if (!if3.busy) begin
        if3.start = ($urandom % 3 == 0);
        if (if3.start) q3.push_back(model(v, 3));
      end else if3.start = ($urandom % 4 == 0);
      v = (r == 4) ? 100 : (r == 5) ? 99 : $urandom % 256;
      if2.bin = 8'(v);
      if (!if2.busy) begin
        if2.start = ($urandom % 3 == 0);
        if (if2.start) q2.push_back(model(v, 2));
      end else if2.start = ($urandom % 4 == 0);
      @(negedge clk);
    end
    if3.start = 1'b0;
    if2.start = 1'b0;
    wait_idle();
    check("dut3 queue drained", 32'(q3.size()), 0);
    check("dut2 queue drained", 32'(q2.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It produces the packed BCD digit vector that the board's BCD-to-7-segment decoders consume, so binary sums and counts can be shown on HEX displays. The start/done handshake is driven by the board-level control logic. Out-of-range results are flagged, and all digits are forced to 4'b1111 so the downstream decoders blank the display.

Parameters:
W, 8, binary input width (W >= 1)
DIGITS, 3, number of BCD output digits (DIGITS >= 1)

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  synchronous, active-high reset
Start  input  1  request conversion of Bin; sampled only in IDLE
Bin  input  W  unsigned binary operand
Busy  output  1  high while a conversion is in progress (LOAD accepted through DONE state)
Done  output  1  one-cycle pulse when a new result is on BCD/Overflow
BCD  output  4*DIGITS  packed digits; digit 0 (units) is BCD[3:0], digit i is BCD[4i+3:4i]
Overflow  output  1  high when the last result exceeded 10^DIGITS - 1

Behaviour:
- Interface: one clock (Clock); reset is synchronous and active-high (Reset); polarity and synchronicity are fixed.
- Reset values:
  - state = IDLE; Busy = 0; Done = 0; BCD = 0; Overflow = 0.
  - Internal shift register, digit register and bit counter are cleared.
- Reset mid-conversion aborts the conversion: no Done pulse, and BCD/Overflow are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If Start = 1 at edge k: capture Bin into the shift register, clear the digit register, clear the sticky overflow bit, clear the counter, go to SHIFT.
  - If Start = 0, stay in IDLE.
- SHIFT (one edge per input bit):
  - Each digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {ovf_bit, digits, shiftreg} is shifted left by 1, with the binary MSB entering digit 0's LSB.
  - Any 1 shifted out of the top digit's MSB sets the sticky overflow bit.
  - Counter increments each edge; after the W-th shift edge (edge k+W) go to DONE.
- DONE (edge k+W+1):
  - BCD <= digit register, or all 4'b1111 if sticky overflow is set.
  - Overflow <= sticky bit; Done = 1 for exactly this cycle; go to IDLE.
- Latency and throughput:
  - Start accepted at edge k gives Done high and results valid from edge k+W+1. Latency is W+1 cycles.
  - Busy is high from edge k to edge k+W+1.
  - Back-to-back: Start high during the Done cycle is accepted at the next edge. Throughput is one conversion per W+2 cycles.
- Start while Busy = 1 is ignored (not queued). Bin is sampled only at the accepting edge; later changes to Bin have no effect.
- BCD and Overflow hold their last values until the next DONE state or Reset. They never show intermediate values.
- Width rules:
  - All digit arithmetic is 4-bit.
  - Bin = 0 gives all-zero digits.
  - No overflow is possible when 2^W - 1 <= 10^DIGITS - 1 (e.g., W=8, DIGITS=3); Overflow then stays 0.
- Done is a registered output and never asserts without a preceding accepted Start.

Test Plan:
- Defaults (W=8, DIGITS=3):
  - Reset for 2 cycles, then Bin=0, Start pulse → Done at 9th edge after accept; BCD=12'h000, Overflow=0.
  - Bin=255, Start at edge k → Busy high edges k..k+8, Done only at k+9; BCD=12'h255, Overflow=0.
  - Bin=99, then Bin=8'd200 applied while Busy, with Start re-pulsed at edge k+3 → second Start ignored; BCD=12'h099; no second Done.
  - Reset asserted at edge k+4 during conversion of Bin=123 → next cycle Busy=0, BCD=0; no Done pulse.
- W=8, DIGITS=2:
  - Bin=100 → Overflow=1, BCD=8'hFF.
  - Then Bin=42 → Overflow=0, BCD=8'h42.
- Back-to-back (defaults): Bin=37, then Start held high continuously with Bin=58 after the first accept.
  - Done pulses at k+9 (BCD=12'h037) and at k+9+10 (BCD=12'h058).
  - Exactly two Done pulses in 20 cycles.
